// File: rtl/sync_ptr_gray.sv
// Gray-pointer clock-domain-crossing synchroniser with registered binary view, update pulse and step delta.
// Optional Gray-step legality checker is compiled in when SYNC_PTR_CHECK_EN is defined.
module sync_ptr_gray #(
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned STAGES   = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr_gray,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   wq_rptr_gray,
    output logic [ADDRSIZE:0]   wq_rptr_bin,
    output logic                ptr_upd,
    output logic [ADDRSIZE:0]   ptr_delta,
    output logic                ptr_err
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] sync_q [STAGES];
    logic [PW-1:0] g_prev;
    logic [PW-1:0] bin_cur_c;
    logic [PW-1:0] bin_prev_c;
    logic          changed_c;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchroniser chain; the last stage is the destination-domain Gray pointer
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr_gray = sync_q[STAGES-1];

    assign bin_cur_c  = gray2bin(wq_rptr_gray);
    assign bin_prev_c = gray2bin(g_prev);
    assign changed_c  = (wq_rptr_gray != g_prev);

    // History, binary view, update pulse and modulo advance all land on the same edge
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            g_prev      <= '0;
            wq_rptr_bin <= '0;
            ptr_upd     <= 1'b0;
            ptr_delta   <= '0;
        end else begin
            g_prev      <= wq_rptr_gray;
            wq_rptr_bin <= bin_cur_c;
            ptr_upd     <= changed_c;
            ptr_delta   <= changed_c ? PW'(bin_cur_c - bin_prev_c) : '0;
        end
    end

`ifdef SYNC_PTR_CHECK_EN
    logic [PW-1:0] gdiff_c;
    logic          step_bad_c;

    // More than one bit set in the XOR means an illegal multi-bit Gray step
    assign gdiff_c    = wq_rptr_gray ^ g_prev;
    assign step_bad_c = ((gdiff_c & PW'(gdiff_c - PW'(1))) != '0);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            ptr_err <= 1'b0;
        end else if (step_bad_c) begin
            ptr_err <= 1'b1;
        end else if (err_clr) begin
            ptr_err <= 1'b0;
        end
    end
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign ptr_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ptr_gray.sv
// Directed bench for sync_ptr_gray: STAGES=2 and STAGES=3 instances checked every cycle against a pointer-history model.
module tb_sync_ptr_gray;

    localparam int unsigned PW = 5;
`ifdef SYNC_PTR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b1;
    logic [PW-1:0] rptr_gray = '0;
    logic          err_clr = 1'b0;

    logic [PW-1:0] wq2, bin2, del2;
    logic          upd2, err2;
    logic [PW-1:0] wq3, bin3, del3;
    logic          upd3, err3;

    int ntests = 0;
    int nfail  = 0;

    sync_ptr_gray #(.ADDRSIZE(4), .STAGES(2)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr_gray(rptr_gray), .err_clr(err_clr),
        .wq_rptr_gray(wq2), .wq_rptr_bin(bin2), .ptr_upd(upd2),
        .ptr_delta(del2), .ptr_err(err2)
    );

    sync_ptr_gray #(.ADDRSIZE(4), .STAGES(3)) dut3 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr_gray(rptr_gray), .err_clr(err_clr),
        .wq_rptr_gray(wq3), .wq_rptr_bin(bin3), .ptr_upd(upd3),
        .ptr_delta(del3), .ptr_err(err3)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: record of every input value sampled since reset release
    logic [PW-1:0] hist [0:1023];
    int            n = 0;
    logic          em2 = 1'b0;
    logic          em3 = 1'b0;

    function automatic logic [PW-1:0] gat(input int k);
        return (k >= 1) ? hist[k] : '0;
    endfunction

    // Synchronised Gray value visible after edge k for a chain of depth s
    function automatic logic [PW-1:0] wqm(input int k, input int s);
        return gat(k - s + 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b = '0;
        for (int i = 0; i < int'(PW); i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic next_err(input logic cur, input int s, input int k, input logic clr);
        logic [PW-1:0] a, p;
        a = wqm(k - 1, s);
        p = wqm(k - 2, s);
        if (!ERR_EN) return 1'b0;
        if ($countones(a ^ p) > 1) return 1'b1;
        if (clr) return 1'b0;
        return cur;
    endfunction

    task automatic cmp_inst(input int s, input logic [PW-1:0] wq, input logic [PW-1:0] bin,
                            input logic upd, input logic [PW-1:0] del, input logic err,
                            input logic em);
        logic [PW-1:0] a, p, ed;
        a  = wqm(n - 1, s);
        p  = wqm(n - 2, s);
        ed = (a != p) ? PW'(g2b(a) - g2b(p)) : '0;
        chk($sformatf("s%0d_wq", s),    32'(wq),  32'(wqm(n, s)));
        chk($sformatf("s%0d_bin", s),   32'(bin), 32'(g2b(a)));
        chk($sformatf("s%0d_upd", s),   32'(upd), 32'(a != p));
        chk($sformatf("s%0d_delta", s), 32'(del), 32'(ed));
        chk($sformatf("s%0d_err", s),   32'(err), 32'(em));
    endtask

    // Per-cycle compare process
    initial forever begin
        @(posedge wclk);
        if (!wrst_n) begin
            n   = 0;
            em2 = 1'b0;
            em3 = 1'b0;
        end else if (n < 1023) begin
            n++;
            hist[n] = rptr_gray;
            em2 = next_err(em2, 2, n, err_clr);
            em3 = next_err(em3, 3, n, err_clr);
        end
        #1;
        cmp_inst(2, wq2, bin2, upd2, del2, err2, em2);
        cmp_inst(3, wq3, bin3, upd3, del3, err3, em3);
    end

    task automatic step(input int k);
        repeat (k) @(posedge wclk);
        #2;
    endtask

    task automatic drive(input logic [PW-1:0] v);
        @(negedge wclk);
        rptr_gray = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wq2"}, 32'(wq2), 0);   chk({tag, "_bin2"}, 32'(bin2), 0);
        chk({tag, "_upd2"}, 32'(upd2), 0); chk({tag, "_del2"}, 32'(del2), 0);
        chk({tag, "_err2"}, 32'(err2), 0); chk({tag, "_wq3"}, 32'(wq3), 0);
        chk({tag, "_bin3"}, 32'(bin3), 0); chk({tag, "_upd3"}, 32'(upd3), 0);
        chk({tag, "_del3"}, 32'(del3), 0); chk({tag, "_err3"}, 32'(err3), 0);
    endtask

    initial begin
        // Reset with a non-zero input present
        rptr_gray = 5'b10101;
        #1 wrst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        step(3);
        chk_all_zero("rst_held");
        drive(5'b00000);
        wrst_n = 1'b1;
        step(3);

        // Latency of a single-bit step through both depths
        drive(5'b00001);
        step(1); chk("lat_e1_wq2", 32'(wq2), 0);
        step(1); chk("lat_e2_wq2", 32'(wq2), 1); chk("lat_e2_upd2", 32'(upd2), 0);
        step(1); chk("lat_e3_bin2", 32'(bin2), 1); chk("lat_e3_upd2", 32'(upd2), 1);
                 chk("lat_e3_del2", 32'(del2), 1); chk("lat_e3_wq3", 32'(wq3), 1);
                 chk("lat_e3_upd3", 32'(upd3), 0);
        step(1); chk("lat_e4_upd2", 32'(upd2), 0); chk("lat_e4_bin3", 32'(bin3), 1);
                 chk("lat_e4_upd3", 32'(upd3), 1); chk("lat_e4_del3", 32'(del3), 1);
        step(1); chk("lat_e5_upd3", 32'(upd3), 0);

        // Back-to-back walk to 31 then wrap to 0
        for (int b = 2; b < 32; b++) drive(PW'(b ^ (b >> 1)));
        drive(5'b00000);
        step(3);
        chk("wrap_bin2", 32'(bin2), 0); chk("wrap_upd2", 32'(upd2), 1);
        chk("wrap_del2", 32'(del2), 1); chk("wrap_err2", 32'(err2), 0);
        step(2);

        // Illegal two-bit step, hold, clear
        drive(5'b00011);
        step(3);
        chk("ill_del2", 32'(del2), 2); chk("ill_err2", 32'(err2), 32'(ERR_EN));
        step(3);
        chk("ill_hold_err2", 32'(err2), 32'(ERR_EN)); chk("ill_hold_upd2", 32'(upd2), 0);
        @(negedge wclk); err_clr = 1'b1;
        @(negedge wclk); err_clr = 1'b0;
        chk("clr_err2", 32'(err2), 0); chk("clr_err3", 32'(err3), 0);

        // Clear coinciding with a new illegal step: set wins
        drive(5'b00000);
        @(negedge wclk);
        @(negedge wclk); err_clr = 1'b1;
        step(1);
        chk("coin_err2", 32'(err2), 32'(ERR_EN)); chk("coin_del2", 32'(del2), 30);
        @(negedge wclk); err_clr = 1'b0;
        step(3);

        // Mid-operation reset with a change in flight
        drive(5'b00001);
        @(posedge wclk);
        #3 wrst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        rptr_gray = 5'b00011;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        step(3);
        chk("mid_upd2", 32'(upd2), 1); chk("mid_del2", 32'(del2), 2);
        chk("mid_err2", 32'(err2), 32'(ERR_EN));
        step(1);
        chk("mid_upd3", 32'(upd3), 1); chk("mid_del3", 32'(del3), 2);
        step(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sync_ptr_gray.md
SYNC_PTR_GRAY -- requirements
Module: sync_ptr_gray

Interface
REQ-001 SHALL provide parameter ADDRSIZE, default 4, FIFO address width; pointer width is PW = ADDRSIZE+1.
REQ-002 SHALL provide parameter STAGES, default 2, synchroniser depth; legal range 2..4.
REQ-003 SHALL have port wclk  input  1  destination-domain clock; the only clock.
REQ-004 SHALL have port wrst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rptr_gray  input  PW  Gray-coded pointer from the foreign domain, asynchronous to wclk.
REQ-006 SHALL have port err_clr  input  1  synchronous clear of ptr_err.
REQ-007 SHALL have port wq_rptr_gray  output  PW  synchronised Gray pointer.
REQ-008 SHALL have port wq_rptr_bin  output  PW  binary equivalent of the synchronised pointer, registered.
REQ-009 SHALL have port ptr_upd  output  1  one-cycle pulse when wq_rptr_bin takes a new value.
REQ-010 SHALL have port ptr_delta  output  PW  modulo-2^PW advance of the pointer, qualified by ptr_upd.
REQ-011 SHALL have port ptr_err  output  1  sticky flag for an illegal multi-bit Gray step.

Function
REQ-012 SHALL sample rptr_gray through a chain of STAGES flops on posedge wclk; wq_rptr_gray is the last stage, latency STAGES edges.
REQ-013 SHALL hold a history register g_prev = wq_rptr_gray delayed by one wclk edge.
REQ-014 SHALL register wq_rptr_bin = gray2bin(wq_rptr_gray), with bin[PW-1] = g[PW-1] and bin[i] = bin[i+1] XOR g[i]; latency STAGES+1 edges from rptr_gray.
REQ-015 SHALL register ptr_upd = (wq_rptr_gray != g_prev), aligned with the wq_rptr_bin update; an unchanged input produces no pulse.
REQ-016 SHALL register ptr_delta = (gray2bin(wq_rptr_gray) - gray2bin(g_prev)) mod 2^PW when the pointers differ, else 0.
REQ-017 SHALL treat wrap-around as a normal step: binary 2^PW-1 to 0 gives ptr_delta = 1 with no error.
REQ-018 SHALL accept back-to-back single-bit changes on consecutive wclk edges, producing ptr_upd on consecutive cycles.
REQ-019 SHALL add no combinational path from any input to any output.

Reset
REQ-020 SHALL, while wrst_n = 0, immediately force all sync stages, g_prev, wq_rptr_gray, wq_rptr_bin, ptr_upd, ptr_delta and ptr_err to 0, independent of wclk.
REQ-021 SHALL, on a mid-operation reset, discard any in-flight pointer; the first sample after release is compared against 0.
REQ-022 SHALL resume sampling on the first posedge wclk after wrst_n deasserts.

Configuration
REQ-023 SHALL compile the Gray-step checker only when macro SYNC_PTR_CHECK_EN is defined.
REQ-024 SHALL, with SYNC_PTR_CHECK_EN defined, set ptr_err on the edge after the Hamming distance between wq_rptr_gray and g_prev exceeds 1.
REQ-025 SHALL, with SYNC_PTR_CHECK_EN defined, clear ptr_err on err_clr = 1; if set and clear coincide, set wins.
REQ-026 SHALL, with SYNC_PTR_CHECK_EN undefined, tie ptr_err to 0, ignore err_clr and leave all other behaviour unchanged.

Verification
REQ-027 SHALL check reset: wrst_n = 0 with rptr_gray = 10101 -> all outputs 0 asynchronously and held 0 until release.
REQ-028 SHALL check latency (ADDRSIZE = 4, STAGES = 2): rptr_gray 00000 -> 00001 -> wq_rptr_gray = 00001 after 2 edges; wq_rptr_bin = 1, ptr_upd = 1, ptr_delta = 1 at edge 3; ptr_upd = 0 at edge 4.
REQ-029 SHALL check wrap: pointer stepped from binary 31 (Gray 10000) to 0 (Gray 00000) -> wq_rptr_bin = 0, ptr_delta = 1, ptr_err = 0.
REQ-030 SHALL check the checker (SYNC_PTR_CHECK_EN defined): rptr_gray 00000 -> 00011 -> ptr_delta = 2, ptr_err = 1 and held; err_clr pulse -> 0; err_clr coinciding with a new illegal step -> ptr_err stays 1.
REQ-031 SHALL check depth (STAGES = 3): one-bit step -> wq_rptr_gray after 3 edges, wq_rptr_bin and ptr_upd after 4 edges.
REQ-032 SHALL check mid-operation reset: wrst_n pulsed low while ptr_err = 1 and a change is in flight -> all outputs 0; after release, rptr_gray held at 00011 -> ptr_upd = 1, ptr_delta = 2, ptr_err = 1 (check enabled).
